// File: rtl/ora_misr.sv
// ---------------------------------------------------------------------------
// ora_misr -- output response analyser built on an 8-bit MISR.
//
// Compacts N_PATTERNS response bytes into a signature and compares that
// signature against golden_sig once the run is over. The MISR uses the same
// feedback polynomial as the pattern generator (taps 7,5,4,3).
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   start        single-cycle request to begin a run (accepted in IDLE/DONE)
//   data_valid   data_in carries a response sample this cycle
//   data_in      response byte from the SPI path under test
//   golden_sig   expected signature, held stable from start until done
//   signature    current MISR contents
//   pattern_cnt  samples accepted in the current run
//   busy         high in RUN and CHECK
//   done         high in DONE
//   pass / fail  compare result, valid while done (both low otherwise)
// ---------------------------------------------------------------------------
module ora_misr #(
  parameter logic [7:0] SEED       = 8'hFF,
  parameter int         N_PATTERNS = 255    // legal range 1..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       data_valid,
  input  logic [7:0] data_in,
  input  logic [7:0] golden_sig,
  output logic [7:0] signature,
  output logic [7:0] pattern_cnt,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  // Count value of the final sample of a run.
  localparam logic [7:0] LAST_CNT = 8'(N_PATTERNS - 1);

  state_t     state, state_nxt;
  logic       load_seed;   // start accepted: reload seed, clear result
  logic       accept;      // sample compacted this edge
  logic       do_check;    // latch the compare result this edge
  logic       fb;
  logic [7:0] next_sig;

  // MISR step: shift left, feedback into bit 0, response byte XORed in.
  assign fb       = signature[7] ^ signature[5] ^ signature[4] ^ signature[3];
  assign next_sig = {signature[6:0], fb} ^ data_in;

  assign busy = (state == RUN) || (state == CHECK);
  assign done = (state == DONE);

  // State register.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples values from before the edge regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and datapath control.
  // NOTE: every output of this block is given a default first; a path that
  // left one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    load_seed = 1'b0;
    accept    = 1'b0;
    do_check  = 1'b0;
    unique case (state)
      // A restart from DONE behaves exactly like a start from IDLE. Any
      // data_valid in the same cycle is dropped in favour of the seed load.
      IDLE, DONE: begin
        if (start) begin
          load_seed = 1'b1;
          state_nxt = RUN;
        end
      end
      // start is ignored here; the run is never restarted mid-flight.
      RUN: begin
        if (data_valid) begin
          accept = 1'b1;
          if (pattern_cnt == LAST_CNT) state_nxt = CHECK;
        end
      end
      CHECK: begin
        do_check  = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. pass/fail are cleared on every start and only set when leaving
  // CHECK, so they can only be high while in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      signature   <= SEED;
      pattern_cnt <= 8'd0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else if (load_seed) begin
      signature   <= SEED;
      pattern_cnt <= 8'd0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else if (accept) begin
      signature   <= next_sig;
      pattern_cnt <= pattern_cnt + 8'd1;
    end else if (do_check) begin
      pass        <= (signature == golden_sig);
      fail        <= (signature != golden_sig);
    end
  end

endmodule

// File: tb/tb_ora_misr.sv
// ---------------------------------------------------------------------------
// tb_ora_misr -- directed self-checking bench for ora_misr.
//
// Three instances share the stimulus: N_PATTERNS=1, N_PATTERNS=2 and the
// default 255. Each scenario task resets, then drives and checks only the
// instance it targets. Inputs change and outputs are sampled 1 ns after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_ora_misr;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       data_valid;
  logic [7:0] data_in;
  logic [7:0] golden_sig;

  logic [7:0] sig1, cnt1, sig2, cnt2, sigd, cntd;
  logic       busy1, done1, pass1, fail1;
  logic       busy2, done2, pass2, fail2;
  logic       busyd, doned, passd, faild;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ora_misr #(.SEED(8'hFF), .N_PATTERNS(1)) u_n1 (
    .clk(clk), .reset(reset), .start(start), .data_valid(data_valid),
    .data_in(data_in), .golden_sig(golden_sig), .signature(sig1),
    .pattern_cnt(cnt1), .busy(busy1), .done(done1), .pass(pass1), .fail(fail1)
  );

  ora_misr #(.SEED(8'hFF), .N_PATTERNS(2)) u_n2 (
    .clk(clk), .reset(reset), .start(start), .data_valid(data_valid),
    .data_in(data_in), .golden_sig(golden_sig), .signature(sig2),
    .pattern_cnt(cnt2), .busy(busy2), .done(done2), .pass(pass2), .fail(fail2)
  );

  ora_misr u_def (
    .clk(clk), .reset(reset), .start(start), .data_valid(data_valid),
    .data_in(data_in), .golden_sig(golden_sig), .signature(sigd),
    .pattern_cnt(cntd), .busy(busyd), .done(doned), .pass(passd), .fail(faild)
  );

  // Reference: LFSR polynomial with taps 7,5,4,3 (mask B8).
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic [7:0] d);
    return lfsr_next(s) ^ d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; data_valid = 1'b0; data_in = 8'h00;
    step();
    reset = 1'b0;
  endtask

  // Reset with start and data_valid also high: reset wins.
  task automatic test_reset();
    reset = 1'b1; start = 1'b1; data_valid = 1'b1; data_in = 8'h5A;
    golden_sig = 8'h00;
    step();
    reset = 1'b0; start = 1'b0; data_valid = 1'b0;
    checks++;
    if ({sigd, cntd, busyd, doned, passd, faild} !== {8'hFF, 8'h00, 4'b0000}) begin
      failures++;
      $display("FAIL reset_state act sig=%h cnt=%h b/d/p/f=%b%b%b%b exp sig=ff cnt=00 0000",
               sigd, cntd, busyd, doned, passd, faild);
    end
    step();
    checks++;
    if ({busyd, sigd, cntd} !== {1'b0, 8'hFF, 8'h00}) begin
      failures++;
      $display("FAIL reset_stays_idle act busy=%b sig=%h cnt=%h exp busy=0 sig=ff cnt=00",
               busyd, sigd, cntd);
    end
  endtask

  // N=1, data 00 -> signature FE, pass.
  task automatic test_single_pass();
    do_reset();
    golden_sig = 8'hFE;
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if ({busy1, sig1, cnt1} !== {1'b1, 8'hFF, 8'h00}) begin
      failures++;
      $display("FAIL n1_after_start act busy=%b sig=%h cnt=%h exp 1 ff 00", busy1, sig1, cnt1);
    end
    data_in = 8'h00; data_valid = 1'b1; step(); data_valid = 1'b0;   // edge E
    checks++;
    if ({busy1, done1, sig1, cnt1} !== {1'b1, 1'b0, 8'hFE, 8'h01}) begin
      failures++;
      $display("FAIL n1_check_state act busy=%b done=%b sig=%h cnt=%h exp 1 0 fe 01",
               busy1, done1, sig1, cnt1);
    end
    step();                                                         // edge E+1
    step();                                                         // edge E+2
    checks++;
    if ({busy1, done1, pass1, fail1, sig1} !== {4'b0110, 8'hFE}) begin
      failures++;
      $display("FAIL n1_pass act b/d/p/f=%b%b%b%b sig=%h exp 0110 fe",
               busy1, done1, pass1, fail1, sig1);
    end
  endtask

  // Restart from DONE with data_valid in the same cycle, then data 01 -> FF, fail.
  task automatic test_single_fail();
    golden_sig = 8'hFE;
    start = 1'b1; data_valid = 1'b1; data_in = 8'h55; step();
    start = 1'b0; data_valid = 1'b0;
    checks++;
    if ({busy1, done1, pass1, fail1, sig1, cnt1} !== {4'b1000, 8'hFF, 8'h00}) begin
      failures++;
      $display("FAIL n1_restart_drops_sample act b/d/p/f=%b%b%b%b sig=%h cnt=%h exp 1000 ff 00",
               busy1, done1, pass1, fail1, sig1, cnt1);
    end
    data_in = 8'h01; data_valid = 1'b1; step(); data_valid = 1'b0;
    step(); step();
    checks++;
    if ({done1, pass1, fail1, sig1} !== {3'b101, 8'hFF}) begin
      failures++;
      $display("FAIL n1_fail act d/p/f=%b%b%b sig=%h exp 101 ff", done1, pass1, fail1, sig1);
    end
  endtask

  // N=2 with a 3-cycle gap (start pulsed in the gap), then data_valid in DONE.
  task automatic test_gap();
    do_reset();
    golden_sig = 8'hFC;
    start = 1'b1; step(); start = 1'b0;
    data_in = 8'h00; data_valid = 1'b1; step(); data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = 8'hAA;
      start   = (i == 1);
      step();
      start   = 1'b0;
      checks++;
      if ({busy2, sig2, cnt2} !== {1'b1, 8'hFE, 8'h01}) begin
        failures++;
        $display("FAIL n2_gap%0d act busy=%b sig=%h cnt=%h exp 1 fe 01", i, busy2, sig2, cnt2);
      end
    end
    data_in = 8'h00; data_valid = 1'b1; step(); data_valid = 1'b0;
    checks++;
    if ({busy2, done2, sig2, cnt2} !== {2'b10, 8'hFC, 8'h02}) begin
      failures++;
      $display("FAIL n2_last_sample act busy=%b done=%b sig=%h cnt=%h exp 1 0 fc 02",
               busy2, done2, sig2, cnt2);
    end
    step();
    checks++;
    if ({done2, pass2, fail2} !== 3'b110) begin
      failures++;
      $display("FAIL n2_pass act d/p/f=%b%b%b exp 110", done2, pass2, fail2);
    end
    data_in = 8'h33; data_valid = 1'b1; step(); step(); data_valid = 1'b0;
    checks++;
    if ({done2, pass2, fail2, sig2, cnt2} !== {3'b110, 8'hFC, 8'h02}) begin
      failures++;
      $display("FAIL n2_done_ignores_data act d/p/f=%b%b%b sig=%h cnt=%h exp 110 fc 02",
               done2, pass2, fail2, sig2, cnt2);
    end
  endtask

  // Default 255-pattern run fed by the pattern generator, optionally with a
  // single-bit error on sample 100.
  task automatic run_full(input bit flip, input logic [7:0] golden,
                          output logic [7:0] expect_sig);
    logic [7:0] p, m, d;
    do_reset();
    golden_sig = golden;
    start = 1'b1; step(); start = 1'b0;
    p = 8'hFF; m = 8'hFF;
    for (int k = 0; k < 255; k++) begin
      d = (flip && k == 100) ? (p ^ 8'h01) : p;
      m = misr_ref(m, d);
      data_in = d; data_valid = 1'b1; step();
      p = lfsr_next(p);
      if (k == 99) begin
        checks++;
        if (cntd !== 8'd100) begin
          failures++;
          $display("FAIL full_cnt100 act=%0d exp=100", cntd);
        end
      end
    end
    data_valid = 1'b0;
    expect_sig = m;
    checks++;
    if ({busyd, doned, cntd} !== {2'b10, 8'd255}) begin
      failures++;
      $display("FAIL full_check_state flip=%0d act busy=%b done=%b cnt=%0d exp 1 0 255",
               flip, busyd, doned, cntd);
    end
    step(); step();
  endtask

  task automatic test_full();
    logic [7:0] good, bad;
    run_full(1'b0, 8'h00, good);   // pre-compute golden
    run_full(1'b0, good, good);
    checks++;
    if ({doned, passd, faild, sigd} !== {3'b110, good}) begin
      failures++;
      $display("FAIL full_pass act d/p/f=%b%b%b sig=%h exp 110 %h", doned, passd, faild, sigd, good);
    end
    run_full(1'b1, good, bad);
    checks++;
    if ({doned, passd, faild, sigd} !== {3'b101, bad} || bad === good) begin
      failures++;
      $display("FAIL full_bitflip act d/p/f=%b%b%b sig=%h exp 101 %h (golden %h)",
               doned, passd, faild, sigd, bad, good);
    end
  endtask

  // Reset after 10 samples abandons the run; data_valid in IDLE is ignored.
  task automatic test_reset_mid_run();
    do_reset();
    golden_sig = 8'h00;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      data_in = 8'(k * 37); data_valid = 1'b1; step();
    end
    checks++;
    if ({busyd, cntd} !== {1'b1, 8'd10}) begin
      failures++;
      $display("FAIL mid_cnt10 act busy=%b cnt=%0d exp 1 10", busyd, cntd);
    end
    reset = 1'b1; start = 1'b1; step(); reset = 1'b0; start = 1'b0;
    checks++;
    if ({sigd, cntd, busyd, doned, passd, faild} !== {8'hFF, 8'h00, 4'b0000}) begin
      failures++;
      $display("FAIL mid_reset act sig=%h cnt=%h b/d/p/f=%b%b%b%b exp ff 00 0000",
               sigd, cntd, busyd, doned, passd, faild);
    end
    data_in = 8'h81; step(); step(); data_valid = 1'b0;
    checks++;
    if ({sigd, cntd, busyd, doned, passd, faild} !== {8'hFF, 8'h00, 4'b0000}) begin
      failures++;
      $display("FAIL idle_ignores_data act sig=%h cnt=%h b/d/p/f=%b%b%b%b exp ff 00 0000",
               sigd, cntd, busyd, doned, passd, faild);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; data_valid = 1'b0; data_in = 8'h00; golden_sig = 8'h00;
    test_reset();
    test_single_pass();
    test_single_fail();
    test_gap();
    test_full();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
